// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin search helper for the dual-port sram arbiter.
package sram_arb_pkg;

   // Owner ids are sized for the largest supported requester count (8).
   localparam int MAX_REQ = 8;
   localparam int IDW     = 3;

   typedef struct packed {
      logic           vld;
      logic           rd;
      logic [IDW-1:0] id;
   } arb_pipe_t;

   typedef struct packed {
      logic           found;
      logic [IDW-1:0] idx;
   } pick_t;

   function automatic pick_t next_valid(input logic [MAX_REQ-1:0] mask,
                                        input logic [IDW-1:0]     start,
                                        input int unsigned        n);
      pick_t          r;
      int unsigned    j;
      logic [IDW-1:0] jj;
      r = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         j  = (32'(start) + k) % n;
         jj = IDW'(j);
         if (k < n && !r.found && mask[jj]) begin
            r.found = 1'b1;
            r.idx   = jj;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of mask at or after start, wrapping.
module rr_picker
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] mask,
   input  logic [IDW-1:0]     start,
   output logic [IDW-1:0]     idx,
   output logic               found
);

   pick_t pick;

   always_comb begin
      pick  = next_valid(MAX_REQ'(mask), start, NUM_REQ);
      idx   = pick.idx;
      found = pick.found;
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port sram among NUM_REQ requesters.
// Optional SRAM_ARB_OUTREG_EN registers q_a/q_b before routing (read latency 2).
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int WIDTH   = 256,
   parameter int DEPTH   = 64,
   parameter int NUM_REQ = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ-1:0]                     req_write,
   input  logic [NUM_REQ-1:0][$clog2(DEPTH)-1:0]  req_addr,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]          req_wdata,
   output logic [NUM_REQ-1:0]                     rsp_valid,
   output logic [NUM_REQ-1:0][WIDTH-1:0]          rsp_rdata,
   output logic                                   enable_a_n,
   output logic                                   write_enable_a_n,
   output logic [$clog2(DEPTH)-1:0]               address_a,
   output logic [WIDTH-1:0]                       data_a,
   input  logic [WIDTH-1:0]                       q_a,
   output logic                                   enable_b_n,
   output logic                                   write_enable_b_n,
   output logic [$clog2(DEPTH)-1:0]               address_b,
   output logic [WIDTH-1:0]                       data_b,
   input  logic [WIDTH-1:0]                       q_b
);

   localparam int AW = $clog2(DEPTH);

   logic [IDW-1:0]               ptr;
   logic [IDW-1:0]               g0, g1;
   logic                         g0_found, g1_found;
   logic [NUM_REQ-1:0]           mask1;
   logic [AW-1:0]                addr0, addr1;
   logic                         wr0, wr1;
   logic [WIDTH-1:0]             wd0, wd1;
   logic                         conflict, issue_a, issue_b;
   arb_pipe_t                    pipe_a_p0, pipe_b_p0, resp_a, resp_b;
   logic [WIDTH-1:0]             rq_a, rq_b;
   logic [NUM_REQ-1:0]           hit_a, hit_b;
   logic [NUM_REQ-1:0][WIDTH-1:0] rdata_hold;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   rr_picker #(.NUM_REQ(NUM_REQ)) u_pick0 (
      .mask(req_valid), .start(ptr), .idx(g0), .found(g0_found)
   );

   assign mask1 = req_valid & ~(NUM_REQ'(1) << g0);

   // Second search starts at g0 with g0 masked off, i.e. the next valid after g0.
   rr_picker #(.NUM_REQ(NUM_REQ)) u_pick1 (
      .mask(mask1), .start(g0), .idx(g1), .found(g1_found)
   );

   always_comb begin
      addr0 = '0;
      addr1 = '0;
      wr0   = 1'b0;
      wr1   = 1'b0;
      wd0   = '0;
      wd1   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == g0) begin
            addr0 = req_addr[i];
            wr0   = req_write[i];
            wd0   = req_wdata[i];
         end
         if (IDW'(i) == g1) begin
            addr1 = req_addr[i];
            wr1   = req_write[i];
            wd1   = req_wdata[i];
         end
      end
   end

   // Same word with any write would race inside the sram; port B backs off.
   assign conflict = (addr0 == addr1) && (wr0 || wr1);
   assign issue_a  = g0_found && !rst;
   assign issue_b  = g1_found && !conflict && !rst;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (issue_a && IDW'(i) == g0) || (issue_b && IDW'(i) == g1);
      end
   end

   assign enable_a_n       = !issue_a;
   assign write_enable_a_n = !(issue_a && wr0);
   assign address_a        = issue_a ? addr0 : '0;
   assign data_a           = issue_a ? wd0 : '0;
   assign enable_b_n       = !issue_b;
   assign write_enable_b_n = !(issue_b && wr1);
   assign address_b        = issue_b ? addr1 : '0;
   assign data_b           = issue_b ? wd1 : '0;

   // Stage p0: issue bookkeeping, aligned with sram q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         pipe_a_p0 <= '0;
         pipe_b_p0 <= '0;
      end else begin
         if (issue_b)      ptr <= wrap_inc(g1);
         else if (issue_a) ptr <= wrap_inc(g0);
         pipe_a_p0 <= '{vld: issue_a, rd: issue_a && !wr0, id: g0};
         pipe_b_p0 <= '{vld: issue_b, rd: issue_b && !wr1, id: g1};
      end
   end

`ifdef SRAM_ARB_OUTREG_EN
   arb_pipe_t        pipe_a_p1, pipe_b_p1;
   logic [WIDTH-1:0] q_a_p1, q_b_p1;

   // Stage p1: registered sram output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_a_p1 <= '0;
         pipe_b_p1 <= '0;
         q_a_p1    <= '0;
         q_b_p1    <= '0;
      end else begin
         pipe_a_p1 <= pipe_a_p0;
         pipe_b_p1 <= pipe_b_p0;
         q_a_p1    <= q_a;
         q_b_p1    <= q_b;
      end
   end

   assign resp_a = pipe_a_p1;
   assign resp_b = pipe_b_p1;
   assign rq_a   = q_a_p1;
   assign rq_b   = q_b_p1;
`else
   assign resp_a = pipe_a_p0;
   assign resp_b = pipe_b_p0;
   assign rq_a   = q_a;
   assign rq_b   = q_b;
`endif

   always_comb begin
      hit_a     = '0;
      hit_b     = '0;
      rsp_valid = '0;
      rsp_rdata = rdata_hold;
      for (int i = 0; i < NUM_REQ; i++) begin
         hit_a[i]     = resp_a.vld && resp_a.rd && (resp_a.id == IDW'(i));
         hit_b[i]     = resp_b.vld && resp_b.rd && (resp_b.id == IDW'(i));
         rsp_valid[i] = hit_a[i] || hit_b[i];
         if (hit_a[i])      rsp_rdata[i] = rq_a;
         else if (hit_b[i]) rsp_rdata[i] = rq_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_hold <= '0;
      else     rdata_hold <= rsp_rdata;
   end

endmodule
